// File: rtl/seven_seg_mux_driver_if.sv
// Display bus for seven_seg_mux_driver.
// The master side (result/status logic) supplies digit data, the load strobe
// and brightness. The slave side (the driver) returns the board pin values.
interface seven_seg_mux_driver_if #(
  parameter int NUM_DIGITS = 4
);
  // digit 0 is the most significant nibble
  logic [4*NUM_DIGITS-1:0] char;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    load;
  logic [3:0]              brightness;
  logic [NUM_DIGITS-1:0]   anode;
  logic [6:0]              LED;
  logic                    dp;
  logic                    frame_done;

  modport master (
    output char,
    output dp_in,
    output blank,
    output load,
    output brightness,
    input  anode,
    input  LED,
    input  dp,
    input  frame_done
  );

  modport slave (
    input  char,
    input  dp_in,
    input  blank,
    input  load,
    input  brightness,
    output anode,
    output LED,
    output dp,
    output frame_done
  );
endinterface

// File: rtl/seven_seg_mux_driver.sv
// Multiplexed seven-segment display driver.
// NUM_DIGITS hex digits are time-multiplexed onto one segment bus, with a
// one-hot anode select. The driver provides:
//   - a double-buffered digit store, so a frame never shows mixed data;
//   - a decimal point and a blanking control for each digit;
//   - PWM brightness;
//   - a one-cycle anti-ghosting gap at the start of every slot.
// Optional feature: define SEVEN_SEG_LZB_EN to enable leading-zero blanking.
module seven_seg_mux_driver #(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_LOG2     = 10,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b0
) (
  input logic                   clk,
  input logic                   rst,
  seven_seg_mux_driver_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // pin levels that mean "off" after polarity is applied
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW}};

  // hex nibble to {a,b,c,d,e,f,g}, 1 = lit
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  // ---- stage p0: scan position and double-buffered digit store ----
  logic [REFRESH_LOG2-1:0] cnt_p0;
  logic [IDX_W-1:0]        idx_p0;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] sh_char;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [4*NUM_DIGITS-1:0] act_char;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_blank;

  logic slot_end;
  logic frame_end;

  assign slot_end  = &cnt_p0;
  assign frame_end = slot_end && (idx_p0 == LAST_IDX);

  // The slot counter runs freely. The digit index steps at the end of each slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0 <= '0;
      idx_p0 <= '0;
    end else begin
      cnt_p0 <= cnt_p0 + 1'b1;
      if (slot_end) begin
        idx_p0 <= (idx_p0 == LAST_IDX) ? '0 : idx_p0 + 1'b1;
      end
    end
  end

  // Capture into shadow on load. Promote shadow to active only at a frame
  // boundary. A load on the boundary itself is held pending until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= 1'b0;
      sh_char   <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      act_char  <= '0;
      act_dp    <= '0;
      act_blank <= '0;
    end else begin
      if (frame_end && pending) begin
        act_char  <= sh_char;
        act_dp    <= sh_dp;
        act_blank <= sh_blank;
      end
      if (bus.load) begin
        sh_char  <= bus.char;
        sh_dp    <= bus.dp_in;
        sh_blank <= bus.blank;
        pending  <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

  // Select the active data for the digit currently being scanned.
  logic [3:0] cur_char;
  logic       cur_dp;
  logic       cur_blank;

  // Pick out the current digit's nibble, decimal point and blank bit.
  always_comb begin
    cur_char  = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_p0 == IDX_W'(i)) begin
        cur_char  = act_char[4*(NUM_DIGITS-1-i) +: 4];
        cur_dp    = act_dp[i];
        cur_blank = act_blank[i];
      end
    end
  end

  logic suppress;

`ifdef SEVEN_SEG_LZB_EN
  logic lead_zero;

  // A digit is suppressed while every digit from digit 0 up to and including
  // it is zero. The last digit always shows, so a zero value still reads "0".
  always_comb begin
    lead_zero = 1'b1;
    suppress  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (act_char[4*(NUM_DIGITS-1-i) +: 4] != 4'h0) begin
        lead_zero = 1'b0;
      end
      if ((idx_p0 == IDX_W'(i)) && (i != NUM_DIGITS - 1)) begin
        suppress = lead_zero;
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  logic                  gap_ok;
  logic                  bright_ok;
  logic                  vld_p0;
  logic [NUM_DIGITS-1:0] anode_p0;
  logic [6:0]            led_p0;
  logic                  dp_p0;

  // Cycle 0 of each slot is always dark, which avoids ghosting. Brightness
  // limits how many of the 16 sub-slots are lit. A suppressed leading zero
  // still drives its anode when its decimal point must show.
  always_comb begin
    gap_ok    = (cnt_p0 != '0);
    bright_ok = (cnt_p0[REFRESH_LOG2-1 -: 4] <= bus.brightness);
    vld_p0    = gap_ok && bright_ok && !cur_blank && (!suppress || cur_dp);
    anode_p0  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      anode_p0[i] = vld_p0 && (idx_p0 == IDX_W'(i));
    end
    led_p0 = (vld_p0 && !suppress) ? hex_to_seg(cur_char) : 7'b0000000;
    dp_p0  = vld_p0 && cur_dp;
  end

  // ---- stage p1: registered pin outputs with polarity applied ----
  logic [NUM_DIGITS-1:0] anode_p1;
  logic [6:0]            led_p1;
  logic                  dp_p1;
  logic                  frame_done_p1;

  // Register the pins so they change cleanly. Reset forces every pin to its off level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode_p1      <= ANODE_OFF;
      led_p1        <= SEG_OFF;
      dp_p1         <= SEG_ACTIVE_LOW;
      frame_done_p1 <= 1'b0;
    end else begin
      anode_p1      <= anode_p0 ^ ANODE_OFF;
      led_p1        <= led_p0 ^ SEG_OFF;
      dp_p1         <= dp_p0 ^ SEG_ACTIVE_LOW;
      frame_done_p1 <= frame_end;
    end
  end

  assign bus.anode      = anode_p1;
  assign bus.LED        = led_p1;
  assign bus.dp         = dp_p1;
  assign bus.frame_done = frame_done_p1;

endmodule
